// File: rtl/latch_bank_write_arbiter_pkg.sv
// Shared types and constants for the latch-bank write arbiter.
// The state encoding is kept as plain 2-bit constants so it matches the original design.
package latch_bank_write_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ENABLE = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    localparam int unsigned EN_CYCLES_MAX = 15;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int unsigned EN_CNT_W = idx_w(EN_CYCLES_MAX + 1);

endpackage

// File: rtl/latch_bank_write_arbiter_if.sv
// Requester-side bus and latch-bank outputs of the write arbiter.
// The master side is the requester/latch-bank side; the slave side is the arbiter.
interface latch_bank_write_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned NWORD = 8,
    parameter int unsigned AW    = latch_bank_write_arbiter_pkg::idx_w(NWORD)
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic               addr_err;
    logic [NWORD-1:0]   latch_enb;
    logic [DW-1:0]      latch_d;
    logic               busy;

    modport master (
        output req, addr, wdata,
        input  gnt, addr_err, latch_enb, latch_d, busy
    );

    modport slave (
        input  req, addr, wdata,
        output gnt, addr_err, latch_enb, latch_d, busy
    );

endinterface

// File: rtl/latch_bank_write_arbiter_rr_arbiter.sv
// Round-robin picker: combinational winner search starting after the last winner,
// with the pointer advanced only when the caller commits to the pick.
module rr_arbiter
    import latch_bank_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            capture_en,
    output logic            any_req,
    output logic [NREQ-1:0] win_oh
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic [IW-1:0] win_idx;
    logic          found;

    // Visit ptr+1 .. ptr+NREQ (mod NREQ); the first requester hit wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(ptr_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        win_oh          = '0;
        win_oh[win_idx] = found;
    end

    assign any_req = |req;

    always_comb begin
        ptr_d = ptr_q;
        if (capture_en && found) begin
            ptr_d = win_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bank_write_arbiter.sv
// Shares one write port of a level-sensitive latch bank among NREQ requesters,
// sequencing each write as setup / enable pulse / hold with registered outputs.
module latch_bank_write_arbiter
    import latch_bank_write_arbiter_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned NWORD     = 8,
    parameter int unsigned EN_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    latch_bank_write_arbiter_if.slave bus
);

    localparam int unsigned AW = idx_w(NWORD);

    state_t                state_q, state_d;
    logic [EN_CNT_W-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0]       owner_q, owner_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [DW-1:0]         wdat_q, wdat_d;

    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  addr_err_q, addr_err_d;
    logic [NWORD-1:0]      latch_enb_q, latch_enb_d;
    logic [DW-1:0]         latch_d_q, latch_d_d;
    logic                  busy_q, busy_d;

    logic [NREQ-1:0]       win_oh;
    logic                  any_req;
    logic                  capture;
    logic [AW-1:0]         sel_addr;
    logic [DW-1:0]         sel_data;

    assign capture = (state_q == ST_IDLE) && any_req;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (idx_w(NREQ))
    ) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (bus.req),
        .capture_en (capture),
        .any_req    (any_req),
        .win_oh     (win_oh)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                sel_addr = bus.addr[i*AW +: AW];
                sel_data = bus.wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        waddr_d = waddr_q;
        wdat_d  = wdat_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SETUP;
                    owner_d = win_oh;
                    waddr_d = sel_addr;
                    wdat_d  = sel_data;
                end
            end
            ST_SETUP: begin
                state_d = ST_ENABLE;
                cnt_d   = EN_CNT_W'(EN_CYCLES - 1);
            end
            ST_ENABLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - EN_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every latch-facing pin is a flop.
    // latch_d only moves on entry to SETUP, when no enable bit can be high.
    always_comb begin
        latch_d_d  = (state_d == ST_SETUP) ? wdat_d : latch_d_q;
        busy_d     = (state_d != ST_IDLE);
        gnt_d      = (state_d == ST_HOLD) ? owner_d : '0;
        addr_err_d = (state_d == ST_HOLD) && (32'(waddr_d) >= NWORD);
        latch_enb_d = '0;
        for (int unsigned w = 0; w < NWORD; w++) begin
            latch_enb_d[w] = (state_d == ST_ENABLE) && (32'(waddr_d) == w);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            owner_q     <= '0;
            waddr_q     <= '0;
            wdat_q      <= '0;
            gnt_q       <= '0;
            addr_err_q  <= 1'b0;
            latch_enb_q <= '0;
            latch_d_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            waddr_q     <= waddr_d;
            wdat_q      <= wdat_d;
            gnt_q       <= gnt_d;
            addr_err_q  <= addr_err_d;
            latch_enb_q <= latch_enb_d;
            latch_d_q   <= latch_d_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.addr_err  = addr_err_q;
    assign bus.latch_enb = latch_enb_q;
    assign bus.latch_d   = latch_d_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/latch_bank_write_arbiter.md
Name: latch_bank_write_arbiter

Overview:
Write controller for a bank of level-sensitive D latches (NWORD words × DW bits). It shares the single write port between NREQ requesters using round-robin arbitration. It sequences each write as setup, enable pulse, then hold, so latch data is stable around the whole transparent window. All latch-facing outputs are registered, so no enable glitches reach the latch bank.

Parameters:
NREQ, 4, number of requesters (2..8)
DW, 8, latch word width in bits
NWORD, 8, number of latch words in the bank
EN_CYCLES, 1, width of the latch enable pulse in clk cycles (1..15)
AW (localparam), $clog2(NWORD), address width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester write request; held high until its gnt is seen
addr  in  NREQ*AW  per-requester target word; slice i = addr[i*AW +: AW]
wdata  in  NREQ*DW  per-requester write data; slice i = wdata[i*DW +: DW]
gnt  out  NREQ  one-cycle completion pulse to the winning requester
addr_err  out  1  one-cycle pulse with gnt when the captured addr >= NWORD
latch_enb  out  NWORD  one-hot enable to the latch words (drives each latch's enb)
latch_d  out  DW  shared data bus to all latch d inputs
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: gnt=0, addr_err=0, latch_enb=0, latch_d=0, busy=0, FSM=IDLE, enable counter=0, rr pointer=NREQ-1 (so requester 0 has first priority).
- FSM states: IDLE, SETUP, ENABLE, HOLD. All outputs are registered and decoded from next state.
- IDLE:
  - If any req bit is high, choose the winner by searching from ptr+1 upward, mod NREQ.
  - Capture the winner index, addr slice and wdata slice; set ptr to the winner; go to SETUP.
  - If no req is high, stay in IDLE.
- SETUP (1 cycle): latch_d = captured data, latch_enb = 0, busy = 1. Then go to ENABLE.
- ENABLE (EN_CYCLES cycles):
  - latch_enb[captured addr] = 1; all other enable bits 0; latch_d held.
  - The counter loads EN_CYCLES-1 on entry and decrements; exit to HOLD when it reaches 0.
- HOLD (1 cycle):
  - latch_enb = 0; latch_d held.
  - gnt[winner] = 1; addr_err = 1 if the captured addr >= NWORD.
  - Then go to IDLE.
- Out-of-range address: latch_enb stays all-0 through ENABLE. The transaction still completes with gnt and addr_err.
- Latency: req sampled high in IDLE at edge 0 → gnt high in cycle 2+EN_CYCLES. Minimum back-to-back period is 3+EN_CYCLES cycles (IDLE counts as one).
- Handshake:
  - A requester keeps req high until the edge at which it sees gnt, and has req low at the following edge.
  - addr and wdata are captured in IDLE, so they need only be valid at grant time.
  - A req still high in IDLE after its own gnt starts a new transaction. Round-robin still favours the other requesters.
- Simultaneous requests: exactly one winner per transaction. With all NREQ requesting continuously, each is served once per NREQ transactions.
- req changes mid-transaction are ignored until the next IDLE. latch_d and the captured address never change between SETUP and the end of HOLD.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). The in-flight write is dropped and no gnt is issued. Latch content written so far is undefined for that word.
- latch_enb is never more than one-hot. It is never high in the same cycle that latch_d changes.

Decomposition:
- Shared package: FSM state typedef (IDLE, SETUP, ENABLE, HOLD, 2-bit encoding), EN_CYCLES limit constant, and a clog2 helper if the toolflow needs one.
- One sub-module, rr_arbiter: combinational pick of the one-hot/index winner from req and ptr, plus a registered ptr update on capture_en. Parameter NREQ.

Test Plan:
- Single write: NREQ=4, EN_CYCLES=1; req[2]=1, addr=5, wdata=8'hA5 at cycle 0 → cycle 1 latch_d=A5 with enb=0; cycle 2 latch_enb=8'b0010_0000; cycle 3 enb=0 and gnt=4'b0100; busy high in cycles 1-3.
- Round-robin: req=4'b1111 held, each requester dropping req after its gnt → grant order 0,1,2,3, with 4 cycles between gnt pulses.
- Fairness: req[0] and req[3] high continuously → gnts alternate 0,3,0,3; no requester is starved.
- EN_CYCLES=3: latch_enb is high for exactly 3 consecutive cycles; gnt arrives 5 cycles after req is sampled; latch_d is stable from SETUP through HOLD.
- Bad address: NWORD=6, addr=7 → latch_enb stays 0 for the whole transaction; gnt and addr_err pulse together.
- Reset mid-ENABLE: assert rst asynchronously → latch_enb, busy and latch_d go to 0 before the next edge, with no gnt. After release, a pending req[1] is served first (ptr=NREQ-1, so requester 0 would win if also pending).
